result_collector: RTL

//   Result buffer directly upstream of the file writer stage.
//   - Fill: captures one N x N matrix of 32-bit results from the multiplier array. Results arrive one per

---
 rtl/result_collector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/result_collector.sv
// Result buffer ahead of the file writer: collects an N x N matrix delivered in any order,
// presents it to the writer while start is high, then recycles itself on the writer's done edge.
module result_collector #(
  parameter int N     = 8,
  parameter int N_LEN = $clog2(N),
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_LEN:0]   in_row,
  input  logic [N_LEN:0]   in_col,
  input  logic [W-1:0]     in_data,
  output logic             start,
  input  logic [N_LEN:0]   rd_i,
  input  logic [N_LEN:0]   rd_j,
  output logic [W-1:0]     value,
  input  logic             wr_done,
  output logic [15:0]      mat_count,
  output logic             dup_err,
  output logic             range_err
);

  localparam int DEPTH  = N * N;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  localparam logic [N_LEN:0]   N_IDX  = (N_LEN + 1)'(N);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_FILL,
    S_DRAIN,
    S_CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        mat_count_q, mat_count_d;
  logic               dup_err_q, dup_err_d;
  logic               range_err_q, range_err_d;
  logic               wr_done_q, wr_done_d;

  logic [W-1:0]       mem_q [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wr_in_range;
  logic               rd_in_range;
  logic               accept;
  logic               done_rise;

  assign wr_in_range = (in_row < N_IDX) && (in_col < N_IDX);
  assign rd_in_range = (rd_i < N_IDX) && (rd_j < N_IDX);
  assign wr_addr     = ADDR_W'(in_row) * ADDR_W'(N) + ADDR_W'(in_col);
  assign rd_addr     = ADDR_W'(rd_i) * ADDR_W'(N) + ADDR_W'(rd_j);

  assign accept      = in_valid && (state_q == S_FILL);
  assign done_rise   = wr_done && !wr_done_q;
  assign wr_done_d   = wr_done;

  always_comb begin
    // NOTE: every variable gets its default before the case so no path leaves one unassigned
    // (which would infer a latch).
    state_d     = state_q;
    mask_d      = mask_q;
    count_d     = count_q;
    mat_count_d = mat_count_q;
    dup_err_d   = dup_err_q;
    range_err_d = range_err_q;
    mem_we      = 1'b0;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          if (wr_in_range) begin
            mem_we = 1'b1;
            if (mask_q[wr_addr]) begin
              dup_err_d = 1'b1;
            end else begin
              mask_d[wr_addr] = 1'b1;
              count_d         = count_q + 1'b1;
            end
          end else begin
            range_err_d = 1'b1;
          end
        end
        if (count_d == FULL) begin
          state_d = S_DRAIN;
        end
      end

      // A done level left over from the previous matrix is filtered by the edge detect.
      S_DRAIN: begin
        if (done_rise) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        mask_d      = '0;
        count_d     = '0;
        mat_count_d = mat_count_q + 16'd1;
        state_d     = S_FILL;
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      mask_q      <= '0;
      count_q     <= '0;
      mat_count_q <= '0;
      dup_err_q   <= 1'b0;
      range_err_q <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      mat_count_q <= mat_count_d;
      dup_err_q   <= dup_err_d;
      range_err_q <= range_err_d;
      wr_done_q   <= wr_done_d;
    end
  end

  // NOTE: storage has no reset; the valid mask alone decides which entries are meaningful,
  // which keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr] <= in_data;
    end
  end

  assign in_ready  = (state_q == S_FILL);
  assign start     = (state_q == S_DRAIN);
  assign value     = (start && rd_in_range) ? mem_q[rd_addr] : '0;
  assign mat_count = mat_count_q;
  assign dup_err   = dup_err_q;
  assign range_err = range_err_q;

endmodule
